// File: rtl/bus_owner_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_owner_arbiter
// Brief    : Round-robin owner arbiter for the shared datapath bus, with a
//            one-cycle turnaround between owners and a bounded hold time.
//            Optional grant/preempt counters: BUS_OWNER_ARBITER_STATS_EN.
// Revision : 1.0
// ============================================================================
module bus_owner_arbiter #(
    parameter int NSRC     = 24,
    parameter int SELW     = 5,
    parameter int MAX_HOLD = 4
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [NSRC-1:0] req,
    input  logic            lock,
    output logic [NSRC-1:0] grant,
    output logic [SELW-1:0] bus_sel,
    output logic            bus_valid,
    output logic            busy
`ifdef BUS_OWNER_ARBITER_STATS_EN
    ,
    output logic [15:0]     grant_count,
    output logic [15:0]     preempt_count
`endif
);

    localparam int HW       = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int HOLD_LIM = (MAX_HOLD < 1) ? 0 : MAX_HOLD - 1;
    localparam int HOLD_SAT = (MAX_HOLD < 1) ? 0 : MAX_HOLD;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t            r_state;
    logic [NSRC-1:0]   r_grant;
    logic [SELW-1:0]   r_sel;
    logic              r_valid;
    logic              r_busy;
    logic [SELW-1:0]   r_last;
    logic [HW-1:0]     r_hold;

    logic              w_found;
    logic [SELW-1:0]   w_win;
    logic              w_owner_req;
    logic              w_others;
    logic              w_hold_hit;
    logic              w_preempt;
    logic              w_take;
    logic              w_leave;

    function automatic logic [SELW-1:0] wrap_idx(input int k);
        return SELW'(k % NSRC);
    endfunction

    // Rotating priority: the slot after the last owner is searched first,
    // the last owner itself is searched last.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 1; i <= NSRC; i++) begin
            if (!w_found && req[wrap_idx(int'(r_last) + i)]) begin
                w_found = 1'b1;
                w_win   = wrap_idx(int'(r_last) + i);
            end
        end
    end

    // r_sel holds the owner index throughout GRANT.
    assign w_owner_req = req[r_sel];
    assign w_others    = |(req & ~r_grant);
    assign w_hold_hit  = (MAX_HOLD != 0) && (r_hold >= HW'(HOLD_LIM));
    assign w_preempt   = (r_state == S_GRANT) && w_owner_req && w_hold_hit &&
                         !lock && w_others;
    assign w_take      = ((r_state == S_IDLE) || (r_state == S_TURN)) && w_found;
    assign w_leave     = (r_state == S_GRANT) && (!w_owner_req || w_preempt);

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_last  <= SELW'(NSRC - 1);
            r_hold  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_TURN: begin
                    r_hold <= '0;
                    if (w_found) begin
                        r_state <= S_GRANT;
                        r_grant <= NSRC'(1) << w_win;
                        r_sel   <= w_win;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_GRANT: begin
                    if (w_leave) begin
                        r_state <= S_TURN;
                        r_last  <= r_sel;
                        r_grant <= '0;
                        r_sel   <= '0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b1;
                        r_hold  <= '0;
                    end else if (r_hold != HW'(HOLD_SAT)) begin
                        r_hold <= r_hold + HW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_sel   <= '0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_hold  <= '0;
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign bus_sel   = r_sel;
    assign bus_valid = r_valid;
    assign busy      = r_busy;

`ifdef BUS_OWNER_ARBITER_STATS_EN
    logic [15:0] r_grant_cnt;
    logic [15:0] r_preempt_cnt;

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_grant_cnt   <= '0;
            r_preempt_cnt <= '0;
        end else begin
            if (w_take && (r_grant_cnt != 16'hFFFF)) begin
                r_grant_cnt <= r_grant_cnt + 16'd1;
            end
            if (w_preempt && (r_preempt_cnt != 16'hFFFF)) begin
                r_preempt_cnt <= r_preempt_cnt + 16'd1;
            end
        end
    end

    assign grant_count   = r_grant_cnt;
    assign preempt_count = r_preempt_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_owner_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_owner_arbiter
// Brief    : Vector table, directed corner sequences and randomized traffic
//            checked against a cycle-level ownership model.
// Revision : 1.0
// ============================================================================
module tb_bus_owner_arbiter;

    localparam int NSRC     = 24;
    localparam int SELW     = 5;
    localparam int MAX_HOLD = 4;

    logic            clock = 1'b0;
    logic            clear = 1'b0;
    logic            lock  = 1'b0;
    logic [NSRC-1:0] req   = '0;
    logic [NSRC-1:0] grant;
    logic [SELW-1:0] bus_sel;
    logic            bus_valid;
    logic            busy;
`ifdef BUS_OWNER_ARBITER_STATS_EN
    logic [15:0]     grant_count;
    logic [15:0]     preempt_count;
`endif

    bus_owner_arbiter #(
        .NSRC     (NSRC),
        .SELW     (SELW),
        .MAX_HOLD (MAX_HOLD)
    ) u_dut (
        .clock         (clock),
        .clear         (clear),
        .req           (req),
        .lock          (lock),
        .grant         (grant),
        .bus_sel       (bus_sel),
        .bus_valid     (bus_valid),
        .busy          (busy)
`ifdef BUS_OWNER_ARBITER_STATS_EN
        ,
        .grant_count   (grant_count),
        .preempt_count (preempt_count)
`endif
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Ownership model: who holds the bus, for how many visible cycles,
    // whether a dead cycle is in progress, and who held it last.
    int m_owner = -1;
    int m_held  = 0;
    int m_gap   = 0;
    int m_last  = NSRC - 1;
    int m_gc    = 0;
    int m_pc    = 0;

    function automatic logic [NSRC-1:0] b(input int k);
        return NSRC'(1) << k;
    endfunction

    function automatic int m_pick(input logic [NSRC-1:0] r);
        for (int i = 1; i <= NSRC; i++) begin
            int k;
            k = (m_last + i) % NSRC;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_step(input logic c, input logic [NSRC-1:0] r, input logic l);
        int w;
        if (!c) begin
            m_owner = -1; m_held = 0; m_gap = 0; m_last = NSRC - 1; m_gc = 0; m_pc = 0;
        end else if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_last = m_owner; m_owner = -1; m_gap = 1;
            end else if (MAX_HOLD != 0 && m_held >= MAX_HOLD && !l &&
                         (r & ~b(m_owner)) != '0) begin
                m_last = m_owner; m_owner = -1; m_gap = 1;
                if (m_pc < 16'hFFFF) m_pc++;
            end else begin
                m_held++;
            end
        end else begin
            w = m_pick(r);
            m_gap = 0;
            if (w >= 0) begin
                m_owner = w; m_held = 1;
                if (m_gc < 16'hFFFF) m_gc++;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string nm, input logic [NSRC-1:0] eg, input int es,
                              input logic ev, input logic eb);
        chk({nm, ".grant"}, 32'(grant), 32'(eg));
        chk({nm, ".sel"}, 32'(bus_sel), 32'(es));
        chk({nm, ".valid"}, 32'(bus_valid), 32'(ev));
        chk({nm, ".busy"}, 32'(busy), 32'(eb));
    endtask

    task automatic check_model(input string nm);
        check_outs(nm, (m_owner >= 0) ? b(m_owner) : '0, (m_owner >= 0) ? m_owner : 0,
                   m_owner >= 0, (m_owner >= 0) || (m_gap != 0));
`ifdef BUS_OWNER_ARBITER_STATS_EN
        chk({nm, ".gcnt"}, 32'(grant_count), 32'(m_gc));
        chk({nm, ".pcnt"}, 32'(preempt_count), 32'(m_pc));
`endif
    endtask

    // Drive one cycle of inputs, let the edge happen, then sample at +1.
    task automatic cyc(input logic c, input logic [NSRC-1:0] r, input logic l);
        clear = c; req = r; lock = l;
        @(posedge clock);
        model_step(c, r, l);
        #1;
    endtask

    typedef struct {
        logic            clr;
        logic [NSRC-1:0] rq;
        logic            lk;
        logic [NSRC-1:0] eg;
        int              es;
        logic            ev;
        logic            eb;
    } vec_t;

    vec_t vt[32];
    int   nv = 0;

    task automatic add(input logic c, input logic [NSRC-1:0] r, input logic l,
                       input logic [NSRC-1:0] eg, input int es, input logic ev, input logic eb);
        vt[nv].clr = c; vt[nv].rq = r; vt[nv].lk = l;
        vt[nv].eg = eg; vt[nv].es = es; vt[nv].ev = ev; vt[nv].eb = eb;
        nv++;
    endtask

    initial begin : main
        logic [NSRC-1:0] rr;
        logic [NSRC-1:0] cur;
        logic            lk;
        logic            clr;
        int              own[4];

        // Reset, idle, single PC request, then lock hold and release.
        add(1'b0, '0, 1'b0, '0, 0, 1'b0, 1'b0);
        add(1'b0, '0, 1'b0, '0, 0, 1'b0, 1'b0);
        add(1'b1, '0, 1'b0, '0, 0, 1'b0, 1'b0);
        add(1'b1, b(20), 1'b0, b(20), 20, 1'b1, 1'b1);
        add(1'b1, b(20), 1'b0, b(20), 20, 1'b1, 1'b1);
        add(1'b1, '0, 1'b0, '0, 0, 1'b0, 1'b1);
        add(1'b1, '0, 1'b0, '0, 0, 1'b0, 1'b0);
        add(1'b1, b(5), 1'b1, b(5), 5, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) add(1'b1, b(5) | b(9), 1'b1, b(5), 5, 1'b1, 1'b1);
        add(1'b1, b(5) | b(9), 1'b0, '0, 0, 1'b0, 1'b1);
        add(1'b1, b(5) | b(9), 1'b0, b(9), 9, 1'b1, 1'b1);
        add(1'b1, '0, 1'b0, '0, 0, 1'b0, 1'b1);
        add(1'b1, '0, 1'b0, '0, 0, 1'b0, 1'b0);

        for (int i = 0; i < nv; i++) begin
            cyc(vt[i].clr, vt[i].rq, vt[i].lk);
            check_outs($sformatf("vec%0d", i), vt[i].eg, vt[i].es, vt[i].ev, vt[i].eb);
        end

        // Round-robin among 3, 17, 21: four cycles each, one dead cycle between.
        cyc(1'b0, '0, 1'b0);
        rr = b(3) | b(17) | b(21);
        own[0] = 3; own[1] = 17; own[2] = 21; own[3] = 3;
        for (int r = 0; r < 4; r++) begin
            for (int h = 0; h < MAX_HOLD; h++) begin
                cyc(1'b1, rr, 1'b0);
                chk("rr_sel", 32'(bus_sel), 32'(own[r]));
                chk("rr_grant", 32'(grant), 32'(b(own[r])));
            end
            if (r < 3) begin
                cyc(1'b1, rr, 1'b0);
                check_outs("rr_gap", '0, 0, 1'b0, 1'b1);
`ifdef BUS_OWNER_ARBITER_STATS_EN
                chk("rr_pcnt", 32'(preempt_count), 32'(r + 1));
`endif
            end
        end

        // Wrap-around from last owner 23.
        cyc(1'b0, '0, 1'b0);
        cyc(1'b1, b(23), 1'b0);
        check_outs("wrap_own23", b(23), 23, 1'b1, 1'b1);
        cyc(1'b1, b(0) | b(22), 1'b0);
        check_outs("wrap_gap", '0, 0, 1'b0, 1'b1);
        cyc(1'b1, b(0) | b(22), 1'b0);
        check_outs("wrap_sel0", b(0), 0, 1'b1, 1'b1);

        // Clear in the middle of a grant drops it without a dead cycle.
        cyc(1'b0, '0, 1'b0);
        cyc(1'b1, b(12), 1'b0);
        check_outs("mid_own12", b(12), 12, 1'b1, 1'b1);
        cyc(1'b1, b(12), 1'b0);
        cyc(1'b0, b(12), 1'b0);
        check_outs("mid_clear", '0, 0, 1'b0, 1'b0);
        cyc(1'b1, b(12), 1'b0);
        check_outs("mid_regrant", b(12), 12, 1'b1, 1'b1);

        // Randomized traffic against the model.
        cyc(1'b0, '0, 1'b0);
        cur = '0;
        lk  = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 3) == 0) cur = cur ^ b($urandom_range(0, NSRC - 1));
            if ($urandom_range(0, 63) == 0) cur = '0;
            if ($urandom_range(0, 11) == 0) lk = ~lk;
            clr = ($urandom_range(0, 299) != 0);
            cyc(clr, cur, lk);
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
